// File: rtl/multi_stream_buffer.sv
// Multi-way sequential instruction stream buffer on the i-cache miss path with LRU stream reallocation.
// Define MULTI_STREAM_BUFFER_STATS_EN to add saturating hit/miss/prefetch counters.
module multi_stream_buffer #(
    parameter int         NUM_STREAMS        = 4,
    parameter int         DEPTH              = 4,
    parameter int         BLOCK_OFFSET_WIDTH = 2,
    parameter int         ADDR_WIDTH         = 26,
    parameter int         DATA_WIDTH         = 32,
    parameter logic [3:0] AXI_ID             = 4'd2,
    localparam int        LINE_WORDS         = 2**BLOCK_OFFSET_WIDTH,
    localparam int        LINE_AW            = ADDR_WIDTH-2-BLOCK_OFFSET_WIDTH,
    localparam int        LINE_W             = LINE_WORDS*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lookup_valid,
    input  logic [LINE_AW-1:0]    lookup_line,
    output logic                  lookup_hit,
    output logic [LINE_W-1:0]     lookup_data,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [3:0]            ARID,
    output logic [3:0]            ARLEN,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic                  RLAST,
    input  logic [3:0]            RID,
    input  logic [DATA_WIDTH-1:0] RDATA
`ifdef MULTI_STREAM_BUFFER_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_prefetches
`endif
);
    localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = (BLOCK_OFFSET_WIDTH > 0) ? BLOCK_OFFSET_WIDTH : 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

    logic [LINE_W-1:0]      line_mem [NUM_STREAMS][DEPTH];
    logic [LINE_AW-1:0]     tag_mem  [NUM_STREAMS][DEPTH];
    logic [NUM_STREAMS-1:0] valid_r;
    logic [PW-1:0]          head_r      [NUM_STREAMS];
    logic [CW-1:0]          count_r     [NUM_STREAMS];
    logic [LINE_AW-1:0]     next_line_r [NUM_STREAMS];
    logic [SW-1:0]          lru_r       [NUM_STREAMS];
    logic [SW-1:0]          lru_next_s  [NUM_STREAMS];
    logic [SW-1:0]          rr_r, fetch_idx_r, hit_idx_s, sel_idx_s, cand_s, touch_idx_s, touch_pos_s, victim_s;
    logic [LINE_AW-1:0]     fetch_line_r;
    logic [BW-1:0]          beat_r;
    logic [LINE_W-1:0]      staging_r, commit_line_s;
    logic [PW-1:0]          tail_s;
    state_t                 state_r, state_next_s;
    logic                   stale_r, hit_any_s, miss_s, sel_found_s;
    logic                   ar_fire_s, beat_fire_s, commit_s, realloc_fetch_s;
    logic [NUM_STREAMS-1:0] pop_vec_s, push_vec_s, realloc_vec_s;
    logic                   unused_s;

    assign unused_s = ^RID;

    // Head-tag compare across streams; the lowest matching index wins.
    always_comb begin
        hit_any_s = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_STREAMS-1; i >= 0; i--) begin
            if (valid_r[i] && (count_r[i] != '0) && (tag_mem[i][head_r[i]] == lookup_line)) begin
                hit_any_s = 1'b1;
                hit_idx_s = SW'(i);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    assign lookup_hit  = lookup_valid && hit_any_s;
    assign lookup_data = lookup_hit ? line_mem[hit_idx_s][head_r[hit_idx_s]] : '0;
    assign miss_s      = lookup_valid && !hit_any_s;
    assign victim_s    = lru_r[0];
    assign touch_idx_s = hit_any_s ? hit_idx_s : victim_s;

    // LRU update: move the touched stream to the MRU end and close the gap.
    always_comb begin
        touch_pos_s = '0;
        for (int p = 0; p < NUM_STREAMS; p++) begin
            if (lru_r[p] == touch_idx_s) begin
                touch_pos_s = SW'(p);
            end else begin
                touch_pos_s = touch_pos_s;
            end
        end
        for (int p = 0; p < NUM_STREAMS; p++) begin
            if (SW'(p) < touch_pos_s) begin
                lru_next_s[p] = lru_r[p];
            end else if (p < NUM_STREAMS-1) begin
                lru_next_s[p] = lru_r[(p+1) % NUM_STREAMS];
            end else begin
                lru_next_s[p] = touch_idx_s;
            end
        end
    end

    // Round-robin search for a valid stream with room for another line.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_s      = '0;
        for (int k = NUM_STREAMS-1; k >= 0; k--) begin
            cand_s = SW'((int'(rr_r) + k) % NUM_STREAMS);
            if (valid_r[cand_s] && (count_r[cand_s] < CW'(DEPTH))) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign ar_fire_s       = (state_r == ST_ADDR) && ARREADY;
    assign beat_fire_s     = (state_r == ST_DATA) && RVALID;
    assign realloc_fetch_s = miss_s && (victim_s == fetch_idx_r);
    assign commit_s        = beat_fire_s && RLAST && !stale_r && !realloc_fetch_s;
    assign tail_s          = head_r[fetch_idx_r] + PW'(count_r[fetch_idx_r]);

    // Per-stream event strobes and the final staged line including the last beat.
    always_comb begin
        commit_line_s = staging_r;
        commit_line_s[int'(beat_r)*DATA_WIDTH +: DATA_WIDTH] = RDATA;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            pop_vec_s[i]     = lookup_hit && (hit_idx_s == SW'(i));
            push_vec_s[i]    = commit_s && (fetch_idx_r == SW'(i));
            realloc_vec_s[i] = miss_s && (victim_s == SW'(i));
        end
    end

    // Prefetch FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = sel_found_s ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_next_s = ARREADY ? ST_DATA : ST_ADDR;
            ST_DATA: state_next_s = (RVALID && RLAST) ? ST_IDLE : ST_DATA;
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign ARVALID = (state_r == ST_ADDR);
    assign RREADY  = (state_r == ST_DATA);
    assign ARID    = AXI_ID;
    assign ARLEN   = 4'(LINE_WORDS-1);
    assign ARADDR  = {fetch_line_r, {(BLOCK_OFFSET_WIDTH+2){1'b0}}};

    // Control state: FSM, burst bookkeeping, LRU order and per-stream FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_r         <= '0;
            fetch_idx_r  <= '0;
            fetch_line_r <= '0;
            stale_r      <= 1'b0;
            beat_r       <= '0;
            staging_r    <= '0;
            valid_r      <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                head_r[i]      <= '0;
                count_r[i]     <= '0;
                next_line_r[i] <= '0;
                lru_r[i]       <= SW'(i);
            end
        end else begin
            state_r <= state_next_s;
            if (lookup_valid) lru_r <= lru_next_s;
            if ((state_r == ST_IDLE) && sel_found_s) begin
                fetch_idx_r  <= sel_idx_s;
                fetch_line_r <= next_line_r[sel_idx_s];
                rr_r         <= SW'((int'(sel_idx_s) + 1) % NUM_STREAMS);
                stale_r      <= miss_s && (victim_s == sel_idx_s);
            end else if (realloc_fetch_s && (state_r != ST_IDLE)) begin
                stale_r <= 1'b1;
            end
            if (ar_fire_s) beat_r <= '0;
            else if (beat_fire_s) beat_r <= beat_r + BW'(1);
            if (beat_fire_s) staging_r[int'(beat_r)*DATA_WIDTH +: DATA_WIDTH] <= RDATA;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (realloc_vec_s[i]) begin
                    valid_r[i]     <= 1'b1;
                    head_r[i]      <= '0;
                    count_r[i]     <= '0;
                    next_line_r[i] <= lookup_line + LINE_AW'(1);
                end else begin
                    if (pop_vec_s[i]) head_r[i] <= head_r[i] + PW'(1);
                    if (push_vec_s[i] && !pop_vec_s[i]) count_r[i] <= count_r[i] + CW'(1);
                    else if (pop_vec_s[i] && !push_vec_s[i]) count_r[i] <= count_r[i] - CW'(1);
                    if (ar_fire_s && !stale_r && (fetch_idx_r == SW'(i)))
                        next_line_r[i] <= next_line_r[i] + LINE_AW'(1);
                end
            end
        end
    end

    // Line storage; an entry becomes visible only through the count update above.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            line_mem[fetch_idx_r][tail_s] <= commit_line_s;
            tag_mem[fetch_idx_r][tail_s]  <= fetch_line_r;
        end
    end

`ifdef MULTI_STREAM_BUFFER_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits       <= 32'd0;
            stat_misses     <= 32'd0;
            stat_prefetches <= 32'd0;
        end else begin
            if (lookup_hit && (stat_hits != 32'hFFFF_FFFF)) stat_hits <= stat_hits + 32'd1;
            if (miss_s && (stat_misses != 32'hFFFF_FFFF)) stat_misses <= stat_misses + 32'd1;
            if (commit_s && (stat_prefetches != 32'hFFFF_FFFF)) stat_prefetches <= stat_prefetches + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_stream_buffer.sv
// Scoreboard bench for multi_stream_buffer: expected AR lines are queued with the stimulus and
// popped by the memory responder; lookup results are compared against a line-data model.
module tb_multi_stream_buffer;
    logic         clk = 1'b0;
    logic         rst, lookup_valid, lookup_hit;
    logic [21:0]  lookup_line;
    logic [127:0] lookup_data;
    logic         ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [3:0]   ARID, ARLEN, RID;
    logic [25:0]  ARADDR;
    logic [31:0]  RDATA;
`ifdef MULTI_STREAM_BUFFER_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_prefetches;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    int          ar_delay = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          exp_pref = 0;
    logic [21:0] exp_ar[$];

    always #5 clk = ~clk;

    multi_stream_buffer dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_line(lookup_line),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA)
`ifdef MULTI_STREAM_BUFFER_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_prefetches(stat_prefetches)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] wdata(input logic [21:0] line, input int w);
        return {8'hA5, line, w[1:0]};
    endfunction

    function automatic logic [127:0] line_data(input logic [21:0] line);
        logic [127:0] d;
        for (int w = 0; w < 4; w++) d[w*32 +: 32] = wdata(line, w);
        return d;
    endfunction

    task automatic push_ar(input logic [21:0] line, input bit committed);
        exp_ar.push_back(line);
        if (committed) exp_pref++;
    endtask

    // One-cycle lookup; optionally aligned with the final accepted beat of a burst.
    task automatic do_lookup(input logic [21:0] line, input logic hit_exp, input bit at_rlast);
        bit found;
        found = 1'b0;
        if (at_rlast) begin
            for (int c = 0; c < 60 && !found; c++) begin
                @(negedge clk); #2;
                if (RVALID && RLAST && RREADY) found = 1'b1;
            end
            check_eq("rlast_seen", found, 1'b1);
        end else begin
            @(negedge clk); #1;
        end
        lookup_valid = 1'b1;
        lookup_line  = line;
        #1;
        check_eq($sformatf("hit_%0h", line), lookup_hit, hit_exp);
        if (hit_exp) check_eq($sformatf("data_%0h", line), lookup_data, line_data(line));
        if (hit_exp) exp_hits++;
        else exp_misses++;
        @(posedge clk); #1;
        lookup_valid = 1'b0;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        check_eq("ar_drain", exp_ar.size(), 0);
    endtask

    // Memory model: accepts each AR after ar_delay cycles, then returns four 1-cycle beats.
    initial begin
        logic [25:0] a;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RID = 4'd2;
        forever begin
            @(negedge clk);
            if (!rst && ARVALID) begin
                a = ARADDR;
                check_eq("ar_expected", exp_ar.size() != 0, 1'b1);
                if (exp_ar.size() != 0) check_eq("araddr", a, {exp_ar.pop_front(), 4'b0000});
                check_eq("arlen", ARLEN, 4'd3);
                check_eq("arid", ARID, 4'd2);
                for (int s = 0; s < ar_delay; s++) begin
                    @(negedge clk);
                    check_eq("ar_stable", {ARVALID, ARADDR, ARLEN}, {1'b1, a, 4'd3});
                end
                ARREADY = 1'b1;
                @(negedge clk);
                ARREADY = 1'b0;
                check_eq("arvalid_drop", ARVALID, 1'b0);
                for (int b = 0; b < 4; b++) begin
                    RVALID = 1'b1;
                    RDATA  = wdata(a[25:4], b);
                    RLAST  = (b == 3);
                    check_eq("rready", RREADY, 1'b1);
                    @(negedge clk);
                end
                RVALID = 1'b0;
                RLAST  = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; lookup_valid = 1'b1; lookup_line = 22'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arvalid", ARVALID, 1'b0);
        check_eq("rst_rready", RREADY, 1'b0);
        check_eq("rst_hit", lookup_hit, 1'b0);
        check_eq("rst_data", lookup_data, 128'h0);
        lookup_valid = 1'b0;
        rst = 1'b0;

        // Miss allocates a stream which fills 0x101..0x104, then stops at DEPTH
        for (int l = 'h101; l <= 'h104; l++) push_ar(22'(l), 1'b1);
        do_lookup(22'h100, 1'b0, 1'b0);
        settle(150);

        // Sequential hits pop and refill
        for (int l = 'h105; l <= 'h107; l++) push_ar(22'(l), 1'b1);
        for (int l = 'h101; l <= 'h103; l++) do_lookup(22'(l), 1'b1, 1'b0);
        settle(150);

        // Pop on the same edge as a commit keeps the count, so exactly one more line follows
        push_ar(22'h108, 1'b1);
        push_ar(22'h109, 1'b1);
        do_lookup(22'h104, 1'b1, 1'b0);
        do_lookup(22'h105, 1'b1, 1'b1);
        settle(150);
        for (int l = 'h10a; l <= 'h10d; l++) push_ar(22'(l), 1'b1);
        for (int l = 'h106; l <= 'h109; l++) do_lookup(22'(l), 1'b1, 1'b0);
        settle(150);

        // Four more streams' worth of misses: the fifth overall evicts the 0x100 stream
        for (int r = 1; r <= 4; r++)
            for (int b = 2; b <= 5; b++) push_ar(22'(b*'h100 + r), 1'b1);
        for (int b = 2; b <= 5; b++) do_lookup(22'(b*'h100), 1'b0, 1'b0);
        settle(400);
        for (int l = 'h102; l <= 'h105; l++) push_ar(22'(l), 1'b1);
        do_lookup(22'h101, 1'b0, 1'b0);
        settle(150);

        // Reallocation while the stream's burst waits on a stalled AR: burst drained and discarded
        ar_delay = 3;
        push_ar(22'h305, 1'b0);
        push_ar(22'h405, 1'b1);
        push_ar(22'h505, 1'b1);
        push_ar(22'h106, 1'b1);
        for (int l = 'h201; l <= 'h204; l++) push_ar(22'(l), 1'b1);
        do_lookup(22'h301, 1'b1, 1'b0);
        do_lookup(22'h401, 1'b1, 1'b0);
        do_lookup(22'h501, 1'b1, 1'b0);
        do_lookup(22'h102, 1'b1, 1'b0);
        do_lookup(22'h200, 1'b0, 1'b0);
        settle(400);
        ar_delay = 0;
        push_ar(22'h205, 1'b1);
        do_lookup(22'h201, 1'b1, 1'b0);
        settle(150);

        // Line address wrap
        for (int l = 0; l <= 3; l++) push_ar(22'(l), 1'b1);
        do_lookup(22'h3F_FFFF, 1'b0, 1'b0);
        settle(150);
        push_ar(22'h4, 1'b1);
        do_lookup(22'h0, 1'b1, 1'b0);
        settle(150);

`ifdef MULTI_STREAM_BUFFER_STATS_EN
        check_eq("stat_hits", stat_hits, 128'(exp_hits));
        check_eq("stat_misses", stat_misses, 128'(exp_misses));
        check_eq("stat_prefetches", stat_prefetches, 128'(exp_pref));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_stream_buffer.md
Name: multi_stream_buffer

Overview:
- Parametrised multi-way instruction stream buffer that replaces the single-stream prefetcher beside the i-cache.
- Holds NUM_STREAMS independent sequential streams, each a FIFO of up to DEPTH complete cache lines, with LRU stream reallocation on a miss.
- Sits on the i-cache miss path. It answers lookups combinationally and issues line-sized prefetch bursts through one read master port of the memory arbiter.

Parameters:
- NUM_STREAMS, 4, number of independent streams (power of 2, ≥1).
- DEPTH, 4, line entries per stream FIFO (power of 2, ≥2).
- BLOCK_OFFSET_WIDTH, 2, log2 words per line; LINE_WORDS = 2**BLOCK_OFFSET_WIDTH.
- ADDR_WIDTH, 26, byte-address width; LINE_AW = ADDR_WIDTH-2-BLOCK_OFFSET_WIDTH.
- DATA_WIDTH, 32, word width.
- AXI_ID, 4'd2, ARID driven on every request.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lookup_valid  in  1  i-cache miss lookup this cycle
- lookup_line  in  LINE_AW  line address of the miss
- lookup_hit  out  1  combinational hit
- lookup_data  out  LINE_WORDS*DATA_WIDTH  hit line; word 0 in LSBs
- ARVALID  out  1  read request valid
- ARREADY  in  1  arbiter accepts request
- ARID  out  4  constant AXI_ID
- ARLEN  out  4  constant LINE_WORDS-1
- ARADDR  out  ADDR_WIDTH  {fetch_line, BLOCK_OFFSET_WIDTH+2 zero bits}
- RVALID  in  1  read beat valid
- RREADY  out  1  beat accept
- RLAST  in  1  final beat
- RID  in  4  beat ID (ignored)
- RDATA  in  DATA_WIDTH  beat data

Behaviour:
- Reset (rst=1 at clk edge): all streams invalid, counts 0, FSM IDLE, ARVALID=0, RREADY=0, lookup_hit=0, lookup_data=0, LRU order 0 (LRU) .. NUM_STREAMS-1 (MRU), round-robin pointer 0. Reset asserted mid-burst abandons the burst immediately; the arbiter is reset together with this block.
- Per stream: valid, head ptr, count (0..DEPTH), next_line (LINE_AW), inflight flag. Entries are visible only once all LINE_WORDS beats are written.
- Lookup: only the head entry of each valid stream with count>0 is compared. lookup_hit=lookup_valid && any head tag == lookup_line; lookup_data = that head line. Ties are impossible by construction; if one occurs anyway, the lowest index wins.
- Hit, next edge: pop the head (head+1 mod DEPTH, count-1); stream becomes MRU.
- Miss (lookup_valid && !hit), next edge: the LRU stream is flushed (count=0, head=0). It is reloaded with valid=1 and next_line=lookup_line+1 (mod 2**LINE_AW, wraps to 0), then becomes MRU. If that stream's burst is in flight, the burst is marked stale.
- Prefetch FSM:
  - IDLE: select the first stream from the round-robin pointer with valid && count<DEPTH. If one exists, latch fetch_line=next_line and the stream index, then go to ADDR. The round-robin pointer moves to index+1.
  - ADDR: ARVALID=1. Stay until ARREADY. On ARREADY, ARVALID drops the next cycle, next_line of the stream increments (wraps), and the FSM goes to DATA.
  - DATA: RREADY=1. Each RVALID beat writes word beat_cnt of the tail entry into a staging line. On RLAST, go to IDLE. If not stale, commit the entry at tail and count+1.
  - Stale burst: all beats are still accepted, then discarded.
  - ARADDR/ARID/ARLEN must hold stable while ARVALID=1 && !ARREADY.
- Simultaneous pop (hit) and commit on the same stream: count unchanged, both take effect.
- Simultaneous miss-reallocation and commit to the reallocated stream: the commit is dropped.
- A lookup matching the in-flight fetch_line but not yet committed is a miss (reallocation proceeds).
- Max occupancy: count never exceeds DEPTH. A stream at DEPTH is not selected.
- Latency: lookup 0 cycles. Prefetch is issued ≥2 cycles after the miss: 1 edge reallocation, then IDLE→ADDR.

Optional Feature:
- Macro: MULTI_STREAM_BUFFER_STATS_EN.
- When defined, adds outputs stat_hits, stat_misses, stat_prefetches (32 bits each). They count hit lookups, miss lookups, and committed non-stale lines, saturate at 2**32-1, and are cleared by rst.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then miss on line 0x100 (memory always ready, 1-cycle beats): ARADDR=0x1010 (line 0x101), ARLEN=3 issued; four lines 0x101..0x104 committed; lookup 0x101 → lookup_hit=1 with correct data; then line 0x105 is prefetched.
- Sequential hits 0x101,0x102,0x103: each hits; stream refills; no AR issued while count=DEPTH.
- Interleave misses 0x100, 0x200, 0x300, 0x400, 0x500 with NUM_STREAMS=4: fifth miss reallocates the stream of 0x100; lookup 0x101 then misses.
- Miss on line 0x200 while a burst for that stream is in flight, ARREADY delayed 3 cycles: ARADDR stable during stall; stale burst fully drained (RREADY=1 for 4 beats) and not committed; next AR is line 0x201.
- Miss on line (2**LINE_AW)-1: next prefetch ARADDR=0 (wrap).
- Hit pop and commit on same stream in same cycle: count unchanged; with MULTI_STREAM_BUFFER_STATS_EN, stat_hits and stat_prefetches each +1.
